// File: rtl/switch_arb_pkg.sv
// rtl/switch_arb_pkg.sv - shared types and constants for the switch output arbiter
package switch_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int N_IN_DEFAULT = 4;
    localparam int N_IN_MAX     = 8;
    localparam int WDOG_W       = 8;

    // Port index following idx, wrapping modulo n.
    function automatic int next_port(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/switch_out_arbiter_if.sv
// rtl/switch_out_arbiter_if.sv - request/select bundle between switch inputs and the output arbiter
interface switch_out_arbiter_if #(
    parameter int N_IN = 4
) ();

    logic [N_IN-1:0] req_in;
    logic [N_IN-1:0] tail_in;
    logic            out_stall;
    logic [N_IN-1:0] mux_sel;
    logic            out_valid;
    logic [N_IN-1:0] grant_out;
    logic            wdog_err;

    modport master (
        output req_in,
        output tail_in,
        output out_stall,
        input  mux_sel,
        input  out_valid,
        input  grant_out,
        input  wdog_err
    );

    modport slave (
        input  req_in,
        input  tail_in,
        input  out_stall,
        output mux_sel,
        output out_valid,
        output grant_out,
        output wdog_err
    );

endinterface

// File: rtl/switch_out_arbiter_rr_picker.sv
// rtl/switch_out_arbiter_rr_picker.sv - combinational round-robin picker (rr_picker)
module rr_picker #(
    parameter int N_IN = 4,
    parameter int PW   = $clog2(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [N_IN-1:0] winner,
    output logic            any_valid
);

    // First requester found scanning upward from rr_ptr, wrapping at N_IN.
    always_comb begin
        winner = '0;
        for (int k = 0; k < N_IN; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N_IN) begin
                j = j - N_IN;
            end
            if (req[j] && (winner == '0)) begin
                winner[j] = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/switch_out_arbiter.sv
// rtl/switch_out_arbiter.sv - packet-locking round-robin output arbiter; SWITCH_ARB_WATCHDOG_EN adds stuck-owner watchdog
module switch_out_arbiter
    import switch_arb_pkg::*;
#(
    parameter int N_IN        = N_IN_DEFAULT,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    switch_out_arbiter_if.slave  bus
);

    localparam int PW = $clog2(N_IN);

    if (N_IN < 2 || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("switch_out_arbiter: N_IN out of range");
    end
    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_bad_wdog
        $error("switch_out_arbiter: WDOG_CYCLES out of range");
    end

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   rr_after_owner;

    logic [N_IN-1:0] win_oh;
    logic            win_any;
    logic [PW-1:0]   win_idx;

    logic            owner_req;
    logic            owner_tail;
    logic            owner_grant;
    logic            wdog_fire;

    logic [N_IN-1:0] mux_sel;
    logic [N_IN-1:0] grant_out;
    logic            out_valid;
    logic            wdog_err;

    rr_picker #(
        .N_IN (N_IN),
        .PW   (PW)
    ) u_rr_picker (
        .req       (bus.req_in),
        .rr_ptr    (rr_ptr_q),
        .winner    (win_oh),
        .any_valid (win_any)
    );

    // One-hot winner to binary index for the owner register.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (win_oh[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign owner_req      = bus.req_in[owner_q];
    assign owner_tail     = bus.tail_in[owner_q];
    assign rr_after_owner = PW'(next_port(int'(owner_q), N_IN));

    // Arbitration state, owner and round-robin pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state and crossbar outputs; the lock is released only by a granted tail or the watchdog.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        mux_sel     = '0;
        grant_out   = '0;
        out_valid   = 1'b0;
        owner_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = LOCKED;
                    owner_d = win_idx;
                end
            end
            LOCKED: begin
                mux_sel[owner_q]   = 1'b1;
                out_valid          = owner_req;
                owner_grant        = owner_req & ~bus.out_stall;
                grant_out[owner_q] = owner_grant;
                if ((owner_grant && owner_tail) || wdog_fire) begin
                    state_d  = IDLE;
                    rr_ptr_d = rr_after_owner;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SWITCH_ARB_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q;
    logic [WDOG_W-1:0] wdog_cnt_d;
    logic              wdog_starved;

    assign wdog_starved = (state_q == LOCKED) && !owner_req;
    assign wdog_fire    = wdog_starved && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
    assign wdog_cnt_d   = (wdog_starved && !wdog_fire) ? wdog_cnt_q + 1'b1 : '0;

    // Count consecutive owner bubbles; the pulse lands in the first cycle after the forced release.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt_q <= '0;
            wdog_err   <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err   <= wdog_fire;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    assign bus.mux_sel   = mux_sel;
    assign bus.grant_out = grant_out;
    assign bus.out_valid = out_valid;
    assign bus.wdog_err  = wdog_err;

endmodule

// File: doc/switch_out_arbiter.md
SWITCH_OUT_ARBITER -- requirements
Module: switch_out_arbiter

Interface
REQ-001 Parameter N_IN, default 4, number of switch input ports competing for this output port (2..8).
REQ-002 Parameter WDOG_CYCLES, default 255, watchdog release threshold in cycles (1..255, 8-bit counter).
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_in  in  N_IN  bit i: input i holds a valid flit routed to this output.
REQ-006 tail_in  in  N_IN  bit i: flit currently on input i is a packet tail (qualified by req_in[i]).
REQ-007 out_stall  in  1  downstream link cannot accept a flit this cycle.
REQ-008 mux_sel  out  N_IN  one-hot crossbar multiplexer select, all-zero when no owner.
REQ-009 out_valid  out  1  crossbar output carries a valid flit this cycle.
REQ-010 grant_out  out  N_IN  one-hot; bit i: flit on input i is consumed this cycle.
REQ-011 wdog_err  out  1  one-cycle pulse on watchdog-forced release.

Function
REQ-012 FSM states: IDLE (no owner) and LOCKED (owner registered, packet in flight).
REQ-013 IDLE: mux_sel, out_valid, grant_out all zero.
REQ-014 IDLE with any req_in bit set at edge t: winner chosen round-robin, search starting at rr_ptr and wrapping modulo N_IN; state LOCKED and mux_sel = onehot(winner) from cycle t+1 (1-cycle arbitration latency).
REQ-015 LOCKED: out_valid = req_in[owner]; grant_out[owner] = req_in[owner] AND NOT out_stall; all other grant bits zero.
REQ-016 out_stall high: no grant, owner, mux_sel and state held.
REQ-017 Granted flit with tail_in[owner] high: next cycle state IDLE, mux_sel zero, rr_ptr = (owner+1) mod N_IN.
REQ-018 Single-flit packet (head = tail): lock lasts exactly the cycle(s) until that flit is granted; minimum 2 cycles per packet, back-to-back packets from different inputs separated by one IDLE cycle.
REQ-019 Non-owner requests in LOCKED are ignored; no preemption.
REQ-020 rr_ptr changes only on packet completion or watchdog release; a requester losing arbitration is guaranteed a grant within N_IN-1 packets.
REQ-021 req_in[owner] deasserting mid-packet (bubble) keeps the lock; out_valid low for that cycle.

Reset
REQ-022 reset high at any edge, including mid-packet: state IDLE, rr_ptr 0, mux_sel 0, out_valid 0, grant_out 0, wdog_err 0, watchdog counter 0, effective next cycle.
REQ-023 reset has priority over every other event at the same edge.

Configuration
REQ-024 Macro SWITCH_ARB_WATCHDOG_EN defined: counter increments each LOCKED cycle with req_in[owner] low, clears on any cycle with req_in[owner] high or in IDLE; on reaching WDOG_CYCLES, next cycle state IDLE, rr_ptr = (owner+1) mod N_IN, wdog_err high one cycle.
REQ-025 Macro not defined: no counter instantiated, wdog_err tied 0, lock held indefinitely; port list identical in both builds.

Structure
REQ-026 Shared package switch_arb_pkg: FSM state enum (IDLE, LOCKED), default N_IN, WDOG counter width constant.
REQ-027 One combinational sub-module rr_picker: inputs req vector and rr_ptr, output one-hot winner and any-valid flag.

Verification
REQ-028 N_IN=4, reset, req_in=0101 one cycle with tail_in=0101, rr_ptr=0 -> cycle+1 mux_sel=0001, grant_out=0001; cycle+2 IDLE, rr_ptr=1.
REQ-029 Continuous req_in=1111, every flit tail -> owners 0,1,2,3,0 in order, one IDLE cycle between grants.
REQ-030 Owner 2 sends 4-flit packet, out_stall high on flit 2 for 3 cycles -> mux_sel=0100 constant, grant_out zero during stall, exactly 4 grants, release after flit 4.
REQ-031 reset asserted on flit 2 of a 3-flit packet -> next cycle all outputs zero, rr_ptr 0; re-arbitration starts from input 0.
REQ-032 SWITCH_ARB_WATCHDOG_EN, WDOG_CYCLES=8, owner 1 drops req_in after head -> after 8 empty cycles state IDLE, wdog_err one-cycle pulse, rr_ptr=2; without macro lock persists, wdog_err stays 0.
